// File: rtl/lat_scoreboard_hazard.sv
// ============================================================================
// lat_scoreboard_hazard: load-use hazard unit with a per-register countdown
// scoreboard of in-flight loads and a saturating stall-cycle counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lat_scoreboard_hazard #(
    parameter int NREG    = 32,
    parameter int REG_W   = 5,
    parameter int MAX_LAT = 3,
    parameter int LAT_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_is_load,
    input  logic [REG_W-1:0] id_rd,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             flush,
    output logic             stall,
    output logic [NREG-1:0]  pending,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] cnt [NREG];
    logic             hit_rs;
    logic             hit_rt;
    logic             issue;
    logic [LAT_W-1:0] lat_clamped;

    // Sources are checked against the pre-issue counters, so a load never
    // stalls on its own destination.
    always_comb begin
        hit_rs      = id_rs_used && (id_rs != '0) && (cnt[id_rs] != '0);
        hit_rt      = id_rt_used && (id_rt != '0) && (cnt[id_rt] != '0);
        stall       = id_valid && !flush && (hit_rs || hit_rt);
        issue       = id_valid && !stall && !flush && id_is_load && (id_rd != '0);
        lat_clamped = (id_lat > MAX_LAT_V) ? MAX_LAT_V : id_lat;
    end

    genvar r;
    generate
        for (r = 0; r < NREG; r++) begin : g_cnt
            if (r == 0) begin : g_zero
                assign cnt[r] = '0;
            end else begin : g_live
                // A new issue overwrites an older in-flight count (younger load wins).
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cnt[r] <= '0;
                    end else if (issue && (id_rd == REG_W'(r))) begin
                        cnt[r] <= lat_clamped;
                    end else if (cnt[r] != '0) begin
                        cnt[r] <= cnt[r] - 1'b1;
                    end
                end
            end
            assign pending[r] = (cnt[r] != '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lat_scoreboard_hazard.sv
// Bench for lat_scoreboard_hazard: two instances (MAX_LAT 3 and 2, 4-bit stall
// counter) against a ready-time model, plus directed literal expectations.
`default_nettype none

module tb_lat_scoreboard_hazard;

    localparam int NREG  = 32;
    localparam int REG_W = 5;
    localparam int LAT_W = 2;
    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic             id_rs_used = 1'b0;
    logic             id_rt_used = 1'b0;
    logic             id_is_load = 1'b0;
    logic [REG_W-1:0] id_rd = '0;
    logic [LAT_W-1:0] id_lat = '0;
    logic             flush = 1'b0;

    logic             stall_a, stall_b;
    logic [NREG-1:0]  pend_a, pend_b;
    logic [CNT_W-1:0] sc_a, sc_b;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    always #5 clk = ~clk;

    lat_scoreboard_hazard #(.NREG(NREG), .REG_W(REG_W), .MAX_LAT(3), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_load(id_is_load),
        .id_rd(id_rd), .id_lat(id_lat), .flush(flush),
        .stall(stall_a), .pending(pend_a), .stall_cycles(sc_a)
    );

    lat_scoreboard_hazard #(.NREG(NREG), .REG_W(REG_W), .MAX_LAT(2), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_load(id_is_load),
        .id_rd(id_rd), .id_lat(id_lat), .flush(flush),
        .stall(stall_b), .pending(pend_b), .stall_cycles(sc_b)
    );

    // Model: each register remembers the first cycle number at which its
    // value is forwardable; a register is pending while cyc is below it.
    int cyc = 0;
    int ready [2][NREG] = '{default: 0};
    int msc   [2]       = '{default: 0};

    function automatic bit m_stall(int k);
        bit hr, ht;
        hr = id_rs_used && (id_rs != 0) && (cyc < ready[k][id_rs]);
        ht = id_rt_used && (id_rt != 0) && (cyc < ready[k][id_rt]);
        return id_valid && !flush && (hr || ht);
    endfunction

    function automatic int m_lat(int k);
        int mx;
        mx = (k == 0) ? 3 : 2;
        return (int'(id_lat) > mx) ? mx : int'(id_lat);
    endfunction

    function automatic logic [NREG-1:0] m_pend(int k);
        logic [NREG-1:0] p;
        for (int r = 0; r < NREG; r++) p[r] = (cyc < ready[k][r]);
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                msc[k] <= 0;
                for (int r = 0; r < NREG; r++) ready[k][r] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_stall(k) && msc[k] < SAT) msc[k] <= msc[k] + 1;
                if (id_valid && !m_stall(k) && !flush && id_is_load && id_rd != 0)
                    ready[k][id_rd] <= cyc + 1 + m_lat(k);
            end
            cyc <= cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && checking) begin
            check("model_stall_a", 32'(stall_a), 32'(m_stall(0)));
            check("model_stall_b", 32'(stall_b), 32'(m_stall(1)));
            check("model_pend_a",  pend_a, m_pend(0));
            check("model_pend_b",  pend_b, m_pend(1));
            check("model_sc_a",    32'(sc_a), 32'(msc[0]));
            check("model_sc_b",    32'(sc_b), 32'(msc[1]));
        end
    end

    task automatic step(input logic v, input int rs, input int rt, input logic rsu,
                        input logic rtu, input logic ld, input int rd, input int lat,
                        input logic fl);
        @(posedge clk);
        #1;
        id_valid   = v;
        id_rs      = REG_W'(rs);
        id_rt      = REG_W'(rt);
        id_rs_used = rsu;
        id_rt_used = rtu;
        id_is_load = ld;
        id_rd      = REG_W'(rd);
        id_lat     = LAT_W'(lat);
        flush      = fl;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic lw(input int rd, input int lat);
        step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, rd, lat, 1'b0);
    endtask

    task automatic use_rs(input int rs, input logic rsu);
        step(1'b1, rs, 0, rsu, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall_a), 32'd0);
        check("reset_pend",  pend_a, 32'd0);
        check("reset_sc",    32'(sc_a), 32'd0);
        #1 rst_n = 1'b1;
        checking = 1'b1;

        // Classic single-bubble load-use
        lw(8, 1);
        check("l1_issue_nostall", 32'(stall_a), 32'd0);
        use_rs(8, 1'b1);
        check("l1_stall", 32'(stall_a), 32'd1);
        check("l1_pend8", 32'(pend_a[8]), 32'd1);
        use_rs(8, 1'b1);
        check("l1_release", 32'(stall_a), 32'd0);
        check("l1_sc", 32'(sc_a), 32'd1);

        // Latency 3, and the clamp to 2 on the second instance
        lw(9, 3);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 0, 9, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
            check("l3_stall", 32'(stall_a), 32'd1);
        end
        check("l3_pend9_before", 32'(pend_a[9]), 32'd1);
        check("clamp_b_released", 32'(stall_b), 32'd0);
        step(1'b1, 0, 9, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        check("l3_release", 32'(stall_a), 32'd0);
        check("l3_pend9_clear", 32'(pend_a[9]), 32'd0);
        check("l3_sc_a", 32'(sc_a), 32'd4);
        check("l3_sc_b", 32'(sc_b), 32'd3);

        // Register 0 and unused sources
        lw(0, 3);
        idle();
        check("r0_no_pend", pend_a, 32'd0);
        lw(8, 2);
        step(1'b1, 8, 0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        check("unused_src_nostall", 32'(stall_a), 32'd0);
        idle();
        idle();

        // WAW: younger load overwrites the older count
        step(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 5, 3, 1'b0);
        step(1'b1, 2, 0, 1'b1, 1'b0, 1'b1, 5, 1, 1'b0);
        check("waw_issue_nostall", 32'(stall_a), 32'd0);
        use_rs(5, 1'b1);
        check("waw_stall", 32'(stall_a), 32'd1);
        use_rs(5, 1'b1);
        check("waw_one_cycle", 32'(stall_a), 32'd0);

        // Flush while a hazard is pending
        lw(8, 3);
        step(1'b1, 8, 0, 1'b1, 1'b0, 1'b1, 10, 3, 1'b1);
        check("flush_nostall", 32'(stall_a), 32'd0);
        idle();
        check("flush_no_issue", 32'(pend_a[10]), 32'd0);
        check("flush_pend8_kept", 32'(pend_a[8]), 32'd1);
        idle();
        check("flush_pend8_late", 32'(pend_a[8]), 32'd1);
        idle();
        check("flush_pend8_clear", 32'(pend_a[8]), 32'd0);

        // Self-dependent load loop saturates the counter
        for (int i = 0; i < 28; i++) step(1'b1, 8, 0, 1'b1, 1'b0, 1'b1, 8, 3, 1'b0);
        check("sat_sc_a", 32'(sc_a), 32'd15);
        check("sat_sc_b", 32'(sc_b), 32'd15);
        for (int i = 0; i < 8 && !stall_a; i++) step(1'b1, 8, 0, 1'b1, 1'b0, 1'b1, 8, 3, 1'b0);
        check("pre_reset_stall", 32'(stall_a), 32'd1);

        // Asynchronous reset in the middle of a stall
        #1 rst_n = 1'b0;
        #1;
        check("rst_stall_a", 32'(stall_a), 32'd0);
        check("rst_stall_b", 32'(stall_b), 32'd0);
        check("rst_pend_a",  pend_a, 32'd0);
        check("rst_sc_a",    32'(sc_a), 32'd0);
        check("rst_sc_b",    32'(sc_b), 32'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 8, 0, 1'b1, 1'b0, 1'b1, 8, 3, 1'b0);
        idle();
        idle();
        @(posedge clk);
        #1;
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lat_scoreboard_hazard.md
Name: lat_scoreboard_hazard

Overview:
- Parametrised load-use hazard unit for the 5-stage pipeline; replaces the single-cycle lw comparator.
- Keeps a per-register countdown scoreboard of in-flight loads (configurable latency per issue).
- Stalls the ID stage while any consumed source register has a result not yet forwardable.
- Counts stall cycles for performance reporting.
- Sits between IF/ID and ID/EX; stall output gates PC/IF-ID write and injects an ID/EX bubble.

Parameters:
- NREG, 32, number of architectural registers.
- REG_W, 5, register index width; NREG = 2**REG_W.
- MAX_LAT, 3, largest accepted load latency in cycles.
- LAT_W, 2, counter width; must hold MAX_LAT.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_W  first source register.
- id_rt  in  REG_W  second source register.
- id_rs_used  in  1  instruction reads rs.
- id_rt_used  in  1  instruction reads rt (includes store data and branch compare).
- id_is_load  in  1  instruction in ID is a load.
- id_rd  in  REG_W  load destination register (rt field for lw).
- id_lat  in  LAT_W  cycles after leaving ID until the load result is forwardable to an ID consumer.
- flush  in  1  kill the ID instruction this cycle (taken branch or jump).
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- pending  out  NREG  bit r set when cnt[r] != 0.
- stall_cycles  out  CNT_W  saturating count of cycles with stall = 1.

Behaviour:
- Reset (async, rst_n = 0): all cnt[r] = 0, pending = 0, stall_cycles = 0. stall evaluates to 0 because every counter is 0.
- Stall equation (combinational, current cycle):
  - hit_rs = id_rs_used && id_rs != 0 && cnt[id_rs] != 0
  - hit_rt = id_rt_used && id_rt != 0 && cnt[id_rt] != 0
  - stall = id_valid && !flush && (hit_rs || hit_rt)
- Issue: the ID instruction issues when id_valid && !stall && !flush && id_is_load && id_rd != 0. At the next edge, cnt[id_rd] <= min(id_lat, MAX_LAT).
  - id_lat = 0 writes 0, i.e. no hazard.
- Decrement: at every edge, each nonzero counter not being written by an issue decrements by 1.
- Same-register collision: an issue to a register whose counter is already nonzero overwrites the counter with the new value. The younger load wins, so WAW needs no stall.
- Self-dependency (for example lw $t0,0($t0)): the issuing instruction's sources are checked against the pre-issue state only, so it never stalls on its own destination.
- Register 0: never written, never causes a stall.
- Latency semantics: a load issued at edge E with lat L sets cnt = L.
  - A consumer in ID during the next L cycles stalls.
  - Cycle E+L+1 is the first cycle it proceeds.
  - L = 1 reproduces the classic single-bubble lw-use stall.
- While stall = 1 the ID instruction does not issue; counters keep decrementing, so stall releases by itself within MAX_LAT cycles.
- flush = 1: stall forced to 0 and no issue that cycle. Counters of older, already-issued loads are unaffected.
- stall_cycles: increments at each edge where stall = 1; saturates at all-ones and does not wrap.
- pending is a registered view of the counters (cnt != 0 per bit) with no extra latency beyond the counter register.
- Reset asserted mid-stall: counters clear immediately, and stall drops in the same cycle (combinationally).

Test Plan:
- Basic lw-use, L=1: issue lw $8 (id_rd=8, id_lat=1); next cycle id_rs=8 used -> stall=1 for exactly 1 cycle, then 0; stall_cycles=1.
- Long latency, L=3: lw $9 issued; consumer reads rt=9 immediately after -> stall high 3 consecutive cycles, pending[9] clears on the third edge; id_lat=3 with MAX_LAT=2 -> stall only 2 cycles (clamped).
- Register 0 and unused sources: lw $0 -> pending stays 0; consumer with id_rs=8 but id_rs_used=0 after lw $8 -> stall=0.
- WAW overwrite: lw $5 lat=3, then next cycle lw $5 lat=1 (independent sources) -> cnt[5]=1 afterwards; consumer of $5 stalls 1 cycle, not 2.
- Flush during hazard: pending[8] set and consumer of $8 in ID with flush=1 -> stall=0, no issue; pending[8] still decrements and clears on schedule.
- Reset and saturation: with CNT_W=4, hold a hazard via repeated issues for 20 stall cycles -> stall_cycles=15; pulse rst_n low mid-stall -> stall=0 and pending=0 immediately, stall_cycles=0.
